// File: rtl/sram_controller.sv
// Word read/write responder: splits each 32-bit access into two 16-bit SRAM accesses, ready returns 2*HALF_CYCLES+1 cycles after the request.
// Backpressure: ready stays low from request until the DONE cycle, so the requester holds its inputs.
module sram_controller #(
  parameter int BASE_ADDR   = 1024,
  parameter int HALF_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n,
  output logic        sram_oe_n
);

  localparam int CW = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          write_q;
  logic [16:0]   idx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [17:0]   sram_addr_q;
  logic [15:0]   sram_dq_out_q;
  logic          sram_dq_oe_q;
  logic          sram_we_n_q;
  logic          sram_oe_n_q;

  logic        req;
  logic        last;
  logic [16:0] idx;

  assign req  = rd_en | wr_en;
  assign last = (cnt_q == CW'(HALF_CYCLES - 1));
  // Index wraps mod 2^17 on purpose; out-of-range addresses alias into the SRAM.
  assign idx  = 17'((address - 32'(BASE_ADDR)) >> 2);

  // Bus outputs are registered one state ahead so they are valid for the whole half-word window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      write_q       <= 1'b0;
      idx_q         <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      sram_addr_q   <= '0;
      sram_dq_out_q <= '0;
      sram_dq_oe_q  <= 1'b0;
      sram_we_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (req) begin
            write_q     <= wr_en;
            idx_q       <= idx;
            wdata_q     <= wdata;
            cnt_q       <= '0;
            state_q     <= LOW;
            sram_addr_q <= {idx, 1'b0};
            if (wr_en) begin
              sram_dq_out_q <= wdata[15:0];
              sram_dq_oe_q  <= 1'b1;
              sram_we_n_q   <= 1'b0;
            end else begin
              sram_oe_n_q <= 1'b0;
            end
          end
        end
        LOW: begin
          if (last) begin
            cnt_q       <= '0;
            state_q     <= HIGH;
            sram_addr_q <= {idx_q, 1'b1};
            if (write_q) sram_dq_out_q <= wdata_q[31:16];
            else         rdata_q[15:0] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        HIGH: begin
          if (last) begin
            cnt_q        <= '0;
            state_q      <= DONE;
            sram_dq_oe_q <= 1'b0;
            sram_we_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            if (!write_q) rdata_q[31:16] <= sram_dq_in;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready       = ((state_q == IDLE) & ~req) | (state_q == DONE);
  assign rdata       = rdata_q;
  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = sram_dq_oe_q;
  assign sram_we_n   = sram_we_n_q;
  assign sram_oe_n   = sram_oe_n_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: HALF_CYCLES=2 instance for write/read/wrap/reset, HALF_CYCLES=1 instance for back-to-back reads.
module tb_sram_controller;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        rd_en0, wr_en0, ready0, dq_oe0, we_n0, oe_n0;
  logic [31:0] address0, wdata0, rdata0;
  logic [17:0] sram_addr0;
  logic [15:0] dq_out0, dq_in0;

  logic        rd_en1, wr_en1, ready1, dq_oe1, we_n1, oe_n1;
  logic [31:0] address1, wdata1, rdata1;
  logic [17:0] sram_addr1;
  logic [15:0] dq_out1, dq_in1;

  logic [15:0] mem0 [0:262143];
  logic [15:0] mem1 [0:262143];

  int vectors = 0;
  int errors  = 0;

  sram_controller #(.BASE_ADDR(1024), .HALF_CYCLES(2)) u0 (
    .clk(clk), .rst(rst), .rd_en(rd_en0), .wr_en(wr_en0), .address(address0),
    .wdata(wdata0), .rdata(rdata0), .ready(ready0), .sram_addr(sram_addr0),
    .sram_dq_out(dq_out0), .sram_dq_in(dq_in0), .sram_dq_oe(dq_oe0),
    .sram_we_n(we_n0), .sram_oe_n(oe_n0)
  );

  sram_controller #(.BASE_ADDR(1024), .HALF_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .rd_en(rd_en1), .wr_en(wr_en1), .address(address1),
    .wdata(wdata1), .rdata(rdata1), .ready(ready1), .sram_addr(sram_addr1),
    .sram_dq_out(dq_out1), .sram_dq_in(dq_in1), .sram_dq_oe(dq_oe1),
    .sram_we_n(we_n1), .sram_oe_n(oe_n1)
  );

  // Simple SRAM models: combinational read when oe_n is low, write captured at the clock edge.
  assign dq_in0 = oe_n0 ? 16'h0000 : mem0[sram_addr0];
  assign dq_in1 = oe_n1 ? 16'h0000 : mem1[sram_addr1];

  always @(posedge clk) begin
    if (!we_n0 && dq_oe0) mem0[sram_addr0] = dq_out0;
    if (!we_n1 && dq_oe1) mem1[sram_addr1] = dq_out1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) begin
      mem0[i] = 16'h0000;
      mem1[i] = 16'h0000;
    end
    mem1[0] = 16'h1111; mem1[1] = 16'h2222; mem1[2] = 16'h3333; mem1[3] = 16'h4444;

    rst = 1'b0;
    rd_en0 = 0; wr_en0 = 0; address0 = 0; wdata0 = 0;
    rd_en1 = 0; wr_en1 = 0; address1 = 0; wdata1 = 0;

    // Reset state
    #12;
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_rdata", rdata0, 32'h0);
    chk("rst_we_n", {31'd0, we_n0}, 32'd1);
    chk("rst_oe_n", {31'd0, oe_n0}, 32'd1);
    chk("rst_dq_oe", {31'd0, dq_oe0}, 32'd0);
    chk("rst_addr", {14'd0, sram_addr0}, 32'd0);
    chk("rst_dq_out", {16'd0, dq_out0}, 32'd0);
    wr_en0 = 1; #1;
    chk("rst_ready_req", {31'd0, ready0}, 32'd0);
    wr_en0 = 0;
    @(negedge clk);
    rst = 1'b1;

    // Write 0xDEADBEEF at 1024
    step;
    wr_en0 = 1; address0 = 32'd1024; wdata0 = 32'hDEADBEEF; #1;
    chk("wr_c0_ready", {31'd0, ready0}, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      step;
      chk("wr_ready", {31'd0, ready0}, (c == 5) ? 32'd1 : 32'd0);
      chk("wr_we_n", {31'd0, we_n0}, (c == 5) ? 32'd1 : 32'd0);
      if (c <= 2) begin
        chk("wr_lo_addr", {14'd0, sram_addr0}, 32'd0);
        chk("wr_lo_dq", {16'd0, dq_out0}, 32'h0000BEEF);
      end else if (c <= 4) begin
        chk("wr_hi_addr", {14'd0, sram_addr0}, 32'd1);
        chk("wr_hi_dq", {16'd0, dq_out0}, 32'h0000DEAD);
      end
    end
    wr_en0 = 0;
    step;
    chk("wr_idle_ready", {31'd0, ready0}, 32'd1);
    chk("wr_mem0", {16'd0, mem0[0]}, 32'h0000BEEF);
    chk("wr_mem1", {16'd0, mem0[1]}, 32'h0000DEAD);

    // Read back at 1024
    rd_en0 = 1; address0 = 32'd1024; #1;
    chk("rd_c0_ready", {31'd0, ready0}, 32'd0);
    for (int c = 1; c <= 5; c++) begin
      step;
      chk("rd_dq_oe", {31'd0, dq_oe0}, 32'd0);
      chk("rd_oe_n", {31'd0, oe_n0}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 1) chk("rd_lo_addr", {14'd0, sram_addr0}, 32'd0);
      if (c == 3) chk("rd_hi_addr", {14'd0, sram_addr0}, 32'd1);
      if (c == 4) chk("rd_c4_ready", {31'd0, ready0}, 32'd0);
    end
    chk("rd_c5_ready", {31'd0, ready0}, 32'd1);
    chk("rd_rdata", rdata0, 32'hDEADBEEF);
    rd_en0 = 0;
    step;

    // Simultaneous rd_en/wr_en is a write; rdata untouched
    rd_en0 = 1; wr_en0 = 1; address0 = 32'd1028; wdata0 = 32'h12345678;
    for (int c = 1; c <= 5; c++) begin
      step;
      if (c == 1) begin
        chk("both_lo_addr", {14'd0, sram_addr0}, 32'd2);
        chk("both_lo_dq", {16'd0, dq_out0}, 32'h00005678);
        chk("both_we_n", {31'd0, we_n0}, 32'd0);
      end
      if (c == 3) begin
        chk("both_hi_addr", {14'd0, sram_addr0}, 32'd3);
        chk("both_hi_dq", {16'd0, dq_out0}, 32'h00001234);
      end
    end
    chk("both_ready", {31'd0, ready0}, 32'd1);
    chk("both_rdata", rdata0, 32'hDEADBEEF);
    rd_en0 = 0; wr_en0 = 0;
    step;
    chk("both_mem2", {16'd0, mem0[2]}, 32'h00005678);
    chk("both_mem3", {16'd0, mem0[3]}, 32'h00001234);

    // Index wrap: 1024 + 4*2^17 aliases to word 0
    wr_en0 = 1; address0 = 32'd525312; wdata0 = 32'hCAFE1234;
    for (int c = 1; c <= 5; c++) begin
      step;
      if (c == 1) chk("wrap_lo_addr", {14'd0, sram_addr0}, 32'd0);
      if (c == 3) chk("wrap_hi_addr", {14'd0, sram_addr0}, 32'd1);
    end
    wr_en0 = 0;
    step;
    rd_en0 = 1; address0 = 32'd1024;
    for (int c = 1; c <= 5; c++) step;
    chk("wrap_rdata", rdata0, 32'hCAFE1234);
    rd_en0 = 0;
    step;

    // Reset in cycle 2 of a write
    wr_en0 = 1; address0 = 32'd1036; wdata0 = 32'hAAAA5555;
    step;
    step;
    chk("mid_we_n_pre", {31'd0, we_n0}, 32'd0);
    rst = 1'b0; #1;
    chk("mid_we_n", {31'd0, we_n0}, 32'd1);
    chk("mid_dq_oe", {31'd0, dq_oe0}, 32'd0);
    chk("mid_rdata", rdata0, 32'h0);
    chk("mid_ready_req", {31'd0, ready0}, 32'd0);
    wr_en0 = 0; #1;
    chk("mid_ready", {31'd0, ready0}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    step;
    chk("post_ready", {31'd0, ready0}, 32'd1);
    chk("post_we_n", {31'd0, we_n0}, 32'd1);
    chk("post_addr", {14'd0, sram_addr0}, 32'd0);
    chk("post_mem6", {16'd0, mem0[6]}, 32'h00005555);
    chk("post_mem7", {16'd0, mem0[7]}, 32'h00000000);

    // HALF_CYCLES=1, back-to-back reads at 1024 and 1028
    rd_en1 = 1; address1 = 32'd1024; #1;
    chk("h1_c0_ready", {31'd0, ready1}, 32'd0);
    for (int c = 1; c <= 7; c++) begin
      step;
      chk("h1_ready", {31'd0, ready1}, (c == 3 || c == 7) ? 32'd1 : 32'd0);
      if (c == 1) chk("h1_addr_c1", {14'd0, sram_addr1}, 32'd0);
      if (c == 2) chk("h1_addr_c2", {14'd0, sram_addr1}, 32'd1);
      if (c == 5) chk("h1_addr_c5", {14'd0, sram_addr1}, 32'd2);
      if (c == 6) chk("h1_addr_c6", {14'd0, sram_addr1}, 32'd3);
      if (c == 3) begin
        chk("h1_rdata0", rdata1, 32'h22221111);
        address1 = 32'd1028;
      end
      if (c == 7) begin
        chk("h1_rdata1", rdata1, 32'h44443333);
        rd_en1 = 0;
      end
    end
    step;
    chk("h1_idle_ready", {31'd0, ready1}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-side responder for the MEM stage's data-memory requests. It accepts one 32-bit word read or write per handshake and services it as two 16-bit half-word accesses on an external asynchronous SRAM. While an access is in flight, `ready` is held low so the pipeline freezes. It sits between the MEM stage and the off-chip SRAM model, replacing the single-cycle data memory.

## Interface
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.
- `HALF_CYCLES`, 2: cycles each half-word access occupies the SRAM bus; must be ≥1.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `rd_en`  in  1  word read request from MEM stage.
- `wr_en`  in  1  word write request from MEM stage.
- `address`  in  32  byte address from the ALU result.
- `wdata`  in  32  store data (Rm value).
- `rdata`  out  32  loaded word; registered.
- `ready`  out  1  high when no access is pending or the current access completes this cycle.
- `sram_addr`  out  18  half-word address to SRAM.
- `sram_dq_out`  out  16  write data to SRAM.
- `sram_dq_in`  in  16  read data from SRAM.
- `sram_dq_oe`  out  1  drive enable for the DQ pad (write only).
- `sram_we_n`  out  1  SRAM write strobe, active-low.
- `sram_oe_n`  out  1  SRAM output enable, active-low.

## Operation
- Word index: `idx = (address - BASE_ADDR) >> 2`, computed mod 2^32. Only `idx[16:0]` is used, so addresses wrap silently.
- Half-word addresses: low half at `{idx[16:0],1'b0}`, high half at `{idx[16:0],1'b1}`.
- Request `req = rd_en | wr_en`. If both are high, the request is a write; `rdata` is unchanged.
- FSM states: IDLE, LOW, HIGH, DONE. A counter `cnt` spans 0..HALF_CYCLES-1.
- IDLE:
  - If `req`, latch the op type (write if `wr_en`), `idx` and `wdata`, clear `cnt`, and go to LOW.
  - Otherwise stay in IDLE.
- LOW:
  - `sram_addr` is the low-half address.
  - Write: `sram_dq_out = wdata_latched[15:0]`, `sram_dq_oe = 1`, `sram_we_n = 0`.
  - Read: `sram_oe_n = 0`; on the cycle `cnt == HALF_CYCLES-1`, sample `sram_dq_in` into `rdata[15:0]`.
  - When `cnt == HALF_CYCLES-1`, clear `cnt` and go to HIGH; otherwise increment `cnt`.
- HIGH: same as LOW with the high-half address, `wdata_latched[31:16]`, and read sampling into `rdata[31:16]`. At the end, go to DONE.
- DONE: `ready = 1`, SRAM bus idle, go to IDLE unconditionally.
- In IDLE and DONE: `sram_we_n = 1`, `sram_oe_n = 1`, `sram_dq_oe = 0`, `sram_addr` holds its last value.
- `ready` is combinational: `(state == IDLE & ~req) | (state == DONE)`.
- The requester must hold `rd_en`/`wr_en`/`address`/`wdata` until it sees `ready`. The controller uses only the values latched in IDLE. Dropping the request mid-access does not abort it; the access completes and DONE still pulses `ready`.
- `rdata` holds the last completed read word indefinitely.

## Timing
- Reset values (asynchronous, on `rst` low):
  - state IDLE, `cnt = 0`, `rdata = 0`, `sram_addr = 0`, `sram_dq_out = 0`.
  - `sram_dq_oe = 0`, `sram_we_n = 1`, `sram_oe_n = 1`.
  - `ready = 1` if `req` is low, else 0.
- Request first high in cycle 0 (state IDLE):
  - LOW occupies cycles 1..H and HIGH occupies cycles H+1..2H, where H = HALF_CYCLES.
  - `ready` is low in cycles 0..2H and high in cycle 2H+1 (DONE).
  - The word is accepted and complete at the rising edge ending cycle 2H+1.
- Default H=2: `ready` is low for 5 cycles and high in cycle 5.
- Back-to-back: a request present in the cycle after DONE starts a new access; no bubble beyond the IDLE cycle.
- Read data: `rdata` is fully valid from cycle 2H+1 (DONE) onward.
- Reset mid-access: the SRAM strobes deassert immediately (asynchronously). A partial write may leave the low half updated. No `ready` pulse is produced for the aborted access.

## Test plan
- Write `0xDEADBEEF` at address 1024, H=2:
  - `sram_addr` = 0 with DQ `0xBEEF` and `we_n = 0` in cycles 1-2.
  - `sram_addr` = 1 with DQ `0xDEAD` in cycles 3-4.
  - `ready` low in cycles 0-4, high in cycle 5.
- Read at address 1024 with SRAM model holding `0xBEEF`/`0xDEAD`: `rdata = 0xDEADBEEF` in cycle 5; `sram_dq_oe` stays 0 throughout.
- `rd_en = wr_en = 1`, address 1028, `wdata = 0x12345678`:
  - Write occurs at half-word addresses 2 and 3.
  - `rdata` keeps its prior value.
- Address `1024 + 4*2^17`: `sram_addr` = 0 then 1 (index wrap).
- Assert `rst` low in cycle 2 of a write:
  - `we_n = 1` and `dq_oe = 0` immediately; `rdata = 0`.
  - After release with no request: `ready = 1` and state is IDLE.
- H=1, two back-to-back reads at 1024 and 1028: `ready` high in cycles 3 and 7; each `rdata` word matches the SRAM model.
